// File: rtl/param_combo_lock_pkg.sv
// Shared lock definitions: state encodings, which the HEX display decoder also uses, and a counter-width helper.
package param_combo_lock_pkg;

    typedef enum logic [2:0] {
        ST_ENTER   = 3'd0,
        ST_OPEN    = 3'd1,
        ST_CLOSED  = 3'd2,
        ST_ERR     = 3'd3,
        ST_LOCKOUT = 3'd4,
        ST_PROG    = 3'd5
    } lock_state_e;

    localparam int unsigned STATE_W = 3;

    // Bits needed to hold the values 0..n, never less than one.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/param_combo_lock_timer.sv
// Lockout timer. o_busy stays high for LOCKOUT_CYC-1 cycles after i_load.
// The owner treats the load cycle as the first cycle of the lockout window.
module combo_lockout_timer
    import param_combo_lock_pkg::*;
#(
    parameter int unsigned LOCKOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_busy
);

    localparam int unsigned CW = cnt_w(LOCKOUT_CYC);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(LOCKOUT_CYC - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/param_combo_lock.sv
// Parametrised keypad combination lock with retry, lockout and code reprogramming.
// All status outputs come straight from registers.
module param_combo_lock
    import param_combo_lock_pkg::*;
#(
    parameter int unsigned DIGITS      = 6,
    parameter int unsigned DIGIT_W     = 4,
    parameter int unsigned RADIX       = 10,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned LOCKOUT_CYC = 16,
    parameter logic [DIGITS*DIGIT_W-1:0] CODE_DEFAULT = 24'h344189
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DIGIT_W-1:0]             digit_in,
    input  logic                           digit_valid,
    input  logic                           prog_en,
    output logic                           open,
    output logic                           closed,
    output logic                           error,
    output logic                           locked_out,
    output logic [$clog2(DIGITS+1)-1:0]    idx,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
    output logic [STATE_W-1:0]             state_o
);

    localparam int unsigned IDX_W = $clog2(DIGITS + 1);
    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

    lock_state_e          r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [TRY_W-1:0]     r_tries;
    logic                 r_mis;
    logic                 r_open;
    logic                 r_closed;
    logic                 r_error;
    logic                 r_locked;
    logic [DIGIT_W-1:0]   r_code [DIGITS];

    logic                 w_bad;
    logic [IDX_W-1:0]     w_cur_idx;
    logic [DIGIT_W-1:0]   w_cur_code;
    logic                 w_mis_next;
    logic                 w_last;
    logic                 w_load;
    logic                 w_busy;
    logic                 w_code_we [DIGITS];

    // A strobe in CLOSED/ERR restarts the attempt, so it is compared as digit 0 with a clean mismatch flag.
    always_comb begin
        w_bad      = 32'(digit_in) >= RADIX;
        w_cur_idx  = (r_state == ST_ENTER) ? r_idx : '0;
        w_cur_code = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (w_cur_idx == IDX_W'(i)) w_cur_code = r_code[i];
        end
        w_mis_next = ((r_state == ST_ENTER) ? r_mis : 1'b0) | (digit_in != w_cur_code);
        w_last     = (w_cur_idx == IDX_W'(DIGITS - 1));
        w_load     = ((r_state == ST_CLOSED) || (r_state == ST_ERR)) && (r_tries == '0);
        for (int unsigned i = 0; i < DIGITS; i++) begin
            w_code_we[i] = (r_state == ST_PROG) && digit_valid && !w_bad && (r_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                r_code[i] <= CODE_DEFAULT[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
            end
        end else begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (w_code_we[i]) r_code[i] <= digit_in;
            end
        end
    end

    combo_lockout_timer #(
        .LOCKOUT_CYC (LOCKOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .o_busy (w_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_ENTER;
            r_idx    <= '0;
            r_tries  <= TRY_W'(MAX_TRIES);
            r_mis    <= 1'b0;
            r_open   <= 1'b0;
            r_closed <= 1'b0;
            r_error  <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            case (r_state)
                ST_ENTER, ST_CLOSED, ST_ERR: begin
                    if (w_load) begin
                        r_state  <= ST_LOCKOUT;
                        r_locked <= 1'b1;
                        r_closed <= 1'b0;
                        r_error  <= 1'b0;
                        r_idx    <= '0;
                    end else if (digit_valid) begin
                        r_closed <= 1'b0;
                        r_error  <= 1'b0;
                        if (w_bad) begin
                            r_state <= ST_ERR;
                            r_error <= 1'b1;
                            r_tries <= r_tries - TRY_W'(1);
                            r_idx   <= '0;
                            r_mis   <= 1'b0;
                        end else if (w_last) begin
                            r_idx <= '0;
                            r_mis <= 1'b0;
                            if (w_mis_next) begin
                                r_state  <= ST_CLOSED;
                                r_closed <= 1'b1;
                                r_tries  <= r_tries - TRY_W'(1);
                            end else begin
                                r_state <= ST_OPEN;
                                r_open  <= 1'b1;
                                r_tries <= TRY_W'(MAX_TRIES);
                            end
                        end else begin
                            r_state <= ST_ENTER;
                            r_idx   <= w_cur_idx + IDX_W'(1);
                            r_mis   <= w_mis_next;
                        end
                    end
                end
                ST_OPEN: begin
                    if (prog_en) begin
                        r_state <= ST_PROG;
                        r_idx   <= '0;
                    end
                end
                ST_PROG: begin
                    r_error <= digit_valid && w_bad;
                    if (digit_valid && !w_bad) begin
                        if (r_idx == IDX_W'(DIGITS - 1)) begin
                            r_state <= ST_ENTER;
                            r_idx   <= '0;
                            r_open  <= 1'b0;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (!w_busy) begin
                        r_state  <= ST_ENTER;
                        r_locked <= 1'b0;
                        r_tries  <= TRY_W'(MAX_TRIES);
                        r_idx    <= '0;
                    end
                end
                default: r_state <= ST_ENTER;
            endcase
        end
    end

    assign open       = r_open;
    assign closed     = r_closed;
    assign error      = r_error;
    assign locked_out = r_locked;
    assign idx        = r_idx;
    assign tries_left = r_tries;
    assign state_o    = r_state;

endmodule
